// File: rtl/tetris_grid_renderer_pkg.sv
// Shared colour encodings and flash-controller state type for the Tetris playfield renderer.
package tetris_pkg;

  typedef logic [2:0] color_t;

  localparam color_t BLACK   = 3'b000;
  localparam color_t BLUE    = 3'b001;
  localparam color_t GREEN   = 3'b010;
  localparam color_t CYAN    = 3'b011;
  localparam color_t RED     = 3'b100;
  localparam color_t MAGENTA = 3'b101;
  localparam color_t YELLOW  = 3'b110;
  localparam color_t WHITE   = 3'b111;

  typedef enum logic [1:0] {IDLE, FLASH, DONE} flash_state_t;

endpackage

// File: rtl/tetris_grid_renderer_line_flash_ctrl.sv
// Line-clear flash sequencer: latches the rows to flash, counts frames per phase,
// toggles the flash phase and ends with a single clear_done pulse.
module line_flash_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS         = 20,
  parameter int FLASH_PERIOD = 4,
  parameter int FLASH_PHASES = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            clear_start,
  input  logic [ROWS-1:0] clear_rows,
  output logic            busy,
  output logic            clear_done,
  output logic            phase,
  output logic [ROWS-1:0] mask
);

  localparam int FW = $clog2(FLASH_PERIOD + 1);
  localparam int PW = $clog2(FLASH_PHASES + 1);

  if (FLASH_PERIOD == 0) begin : g_chk_period
    $error("FLASH_PERIOD must be non-zero");
  end
  if (FLASH_PHASES == 0) begin : g_chk_phases
    $error("FLASH_PHASES must be non-zero");
  end

  flash_state_t    r_state;
  flash_state_t    w_state_nxt;
  logic [FW-1:0]   r_frame_cnt;
  logic [PW-1:0]   r_phase_cnt;
  logic            r_phase;
  logic            r_clear_done;
  logic [ROWS-1:0] r_mask;
  logic            w_last_frame;
  logic            w_last_phase;

  assign w_last_frame = (r_frame_cnt == FW'(FLASH_PERIOD - 1));
  assign w_last_phase = (r_phase_cnt == PW'(FLASH_PHASES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_start) w_state_nxt = (|clear_rows) ? FLASH : DONE;
      FLASH:   if (frame_start && w_last_frame && w_last_phase) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Phase is forced low on the way into DONE so the last cycle of busy never flashes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt  <= '0;
      r_phase_cnt  <= '0;
      r_phase      <= 1'b0;
      r_clear_done <= 1'b0;
      r_mask       <= '0;
    end else begin
      r_clear_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (clear_start && (|clear_rows)) begin
            r_mask      <= clear_rows;
            r_frame_cnt <= '0;
            r_phase_cnt <= '0;
            r_phase     <= 1'b1;
          end
        end
        FLASH: begin
          if (frame_start) begin
            if (w_last_frame) begin
              r_frame_cnt <= '0;
              r_phase_cnt <= r_phase_cnt + 1'b1;
              r_phase     <= w_last_phase ? 1'b0 : ~r_phase;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_mask      <= '0;
          r_frame_cnt <= '0;
          r_phase_cnt <= '0;
          r_phase     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign clear_done = r_clear_done;
  assign phase      = r_phase;
  assign mask       = r_mask;

endmodule

// File: rtl/tetris_grid_renderer.sv
// Two-stage playfield renderer: stage 1 classifies the pixel against the grid,
// stage 2 picks the colour by priority and registers it.
module tetris_grid_renderer
  import tetris_pkg::*;
#(
  parameter int         ROWS         = 20,
  parameter int         COLS         = 10,
  parameter int         CELL_LOG2    = 4,
  parameter int         X0           = 240,
  parameter int         Y0           = 80,
  parameter int         FLASH_PERIOD = 4,
  parameter int         FLASH_PHASES = 6,
  parameter logic [2:0] LINE_COLOR   = 3'b001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 frame_start,
  input  logic [ROWS*COLS-1:0] display_array,
  input  logic [ROWS*COLS-1:0] active_mask,
  input  logic [2:0]           active_color,
  input  logic [2:0]           stored_color,
  input  logic                 gameover,
  input  logic                 clear_start,
  input  logic [ROWS-1:0]      clear_rows,
  output logic                 busy,
  output logic                 clear_done,
  output logic [2:0]           color_out
);

  localparam int GRID_W = COLS << CELL_LOG2;
  localparam int GRID_H = ROWS << CELL_LOG2;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW     = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  if (X0 + GRID_W > 1023) begin : g_chk_x
    $error("grid exceeds horizontal pixel range");
  end
  if (Y0 + GRID_H > 1023) begin : g_chk_y
    $error("grid exceeds vertical pixel range");
  end

  logic            w_busy;
  logic            w_phase;
  logic [ROWS-1:0] w_mask;

  line_flash_ctrl #(
    .ROWS         (ROWS),
    .FLASH_PERIOD (FLASH_PERIOD),
    .FLASH_PHASES (FLASH_PHASES)
  ) u_flash (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .clear_start (clear_start),
    .clear_rows  (clear_rows),
    .busy        (w_busy),
    .clear_done  (clear_done),
    .phase       (w_phase),
    .mask        (w_mask)
  );

  assign busy = w_busy;

  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic        w_in_grid;
  logic        w_on_line;
  logic        w_on_border;
  logic        w_ring_x;
  logic        w_ring_y;

  assign w_dx    = x - 10'(X0);
  assign w_dy    = y - 10'(Y0);
  assign w_x_ext = {1'b0, x};
  assign w_y_ext = {1'b0, y};

  assign w_in_grid = (w_x_ext >= 11'(X0)) && (w_x_ext < 11'(X0 + GRID_W)) &&
                     (w_y_ext >= 11'(Y0)) && (w_y_ext < 11'(Y0 + GRID_H));
  assign w_on_line = w_in_grid &&
                     ((w_dx[CELL_LOG2-1:0] == '0) || (w_dy[CELL_LOG2-1:0] == '0));

  // The +1 on the pixel side keeps the left/top ring test free of underflow when X0/Y0 is 0.
  assign w_ring_x    = (w_x_ext + 11'd1 >= 11'(X0)) && (w_x_ext <= 11'(X0 + GRID_W));
  assign w_ring_y    = (w_y_ext + 11'd1 >= 11'(Y0)) && (w_y_ext <= 11'(Y0 + GRID_H));
  assign w_on_border = w_ring_x && w_ring_y && !w_in_grid;

  // ---- stage 1: pixel classification and cell coordinates ----
  logic          r_in_grid_p1;
  logic          r_on_line_p1;
  logic          r_on_border_p1;
  logic [RW-1:0] r_row_p1;
  logic [CW-1:0] r_col_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_grid_p1   <= 1'b0;
      r_on_line_p1   <= 1'b0;
      r_on_border_p1 <= 1'b0;
      r_row_p1       <= '0;
      r_col_p1       <= '0;
    end else begin
      r_in_grid_p1   <= w_in_grid;
      r_on_line_p1   <= w_on_line;
      r_on_border_p1 <= w_on_border;
      r_row_p1       <= RW'(w_dy >> CELL_LOG2);
      r_col_p1       <= CW'(w_dx >> CELL_LOG2);
    end
  end

  // ---- stage 2: priority colour select ----
  logic [IW-1:0] w_idx;
  color_t        w_color;
  color_t        r_color_p2;

  assign w_idx = IW'(r_row_p1) * IW'(COLS) + IW'(r_col_p1);

  always_comb begin
    w_color = BLACK;
    if (r_on_border_p1)                           w_color = WHITE;
    else if (!r_in_grid_p1)                       w_color = BLACK;
    else if (w_mask[r_row_p1] && w_busy && w_phase) w_color = WHITE;
    else if (active_mask[w_idx])                  w_color = active_color;
    else if (display_array[w_idx])                w_color = gameover ? RED : stored_color;
    else if (r_on_line_p1)                        w_color = LINE_COLOR;
    else                                          w_color = BLACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_color_p2 <= BLACK;
    else        r_color_p2 <= w_color;
  end

  assign color_out = r_color_p2;

endmodule

// File: tb/tb_tetris_grid_renderer.sv
// Directed bench for tetris_grid_renderer at default parameters.
module tb_tetris_grid_renderer;

  logic         clk;
  logic         rst_n;
  logic [9:0]   x;
  logic [9:0]   y;
  logic         frame_start;
  logic [199:0] display_array;
  logic [199:0] active_mask;
  logic [2:0]   active_color;
  logic [2:0]   stored_color;
  logic         gameover;
  logic         clear_start;
  logic [19:0]  clear_rows;
  logic         busy;
  logic         clear_done;
  logic [2:0]   color_out;

  int n_total;
  int n_bad;

  tetris_grid_renderer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .x             (x),
    .y             (y),
    .frame_start   (frame_start),
    .display_array (display_array),
    .active_mask   (active_mask),
    .active_color  (active_color),
    .stored_color  (stored_color),
    .gameover      (gameover),
    .clear_start   (clear_start),
    .clear_rows    (clear_rows),
    .busy          (busy),
    .clear_done    (clear_done),
    .color_out     (color_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int px_x, input int px_y, input logic [2:0] exp, input string tag);
    x = 10'(px_x);
    y = 10'(px_y);
    tick();
    tick();
    chk(tag, 32'(color_out), 32'(exp));
  endtask

  logic seen_done;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0; x = '0; y = '0; frame_start = 1'b0;
    display_array = '0; active_mask = '0; active_color = '0; stored_color = '0;
    gameover = 1'b0; clear_start = 1'b0; clear_rows = '0;

    repeat (3) tick();
    chk("rst_color", 32'(color_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_origin_color", 32'(color_out), 32'd0);
    end

    display_array[0] = 1'b1;
    stored_color = 3'b011;
    px(245, 85, 3'b011, "stored_block");
    gameover = 1'b1;
    px(245, 85, 3'b100, "gameover_tint");
    gameover = 1'b0;

    display_array[199] = 1'b1;
    active_mask[199]   = 1'b1;
    active_color       = 3'b110;
    px(390, 390, 3'b110, "piece_priority");

    px(239, 100, 3'b111, "border_left");
    px(256, 100, 3'b001, "grid_line");
    px(257, 101, 3'b000, "empty_cell");
    px(400, 100, 3'b111, "border_right");
    px(400, 400, 3'b111, "border_corner");
    px(240,  80, 3'b011, "block_over_line");
    px(401, 100, 3'b000, "outside");

    x = 10'd390; y = 10'd390;
    clear_rows  = 20'h80000;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("flash_busy", 32'(busy), 32'd1);
    clear_rows  = 20'h00001;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("flash_busy_ignore", 32'(busy), 32'd1);
    px(245, 85, 3'b011, "no_requeue_row0");
    x = 10'd390; y = 10'd390;
    tick();
    tick();

    for (int f = 0; f < 24; f++) begin
      chk($sformatf("flash_color_f%0d", f), 32'(color_out),
          ((f / 4) % 2 == 0) ? 32'd7 : 32'd6);
      chk("flash_no_early_done", 32'(clear_done), 32'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (f < 23) begin
        tick();
        tick();
      end
    end
    chk("done_not_yet", 32'(clear_done), 32'd0);
    tick();
    chk("done_pulse", 32'(clear_done), 32'd1);
    chk("done_busy_low", 32'(busy), 32'd0);
    tick();
    chk("done_single", 32'(clear_done), 32'd0);
    chk("after_flash_color", 32'(color_out), 32'd6);

    clear_rows  = '0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("zero_done_wait", 32'(clear_done), 32'd0);
    tick();
    chk("zero_done_pulse", 32'(clear_done), 32'd1);
    chk("zero_no_flash", 32'(color_out), 32'd6);
    tick();
    chk("zero_done_single", 32'(clear_done), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);

    clear_rows  = 20'h80000;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int f = 0; f < 10; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_color", 32'(color_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      frame_start = (i % 2 == 0);
      tick();
      if (clear_done) seen_done = 1'b1;
    end
    frame_start = 1'b0;
    chk("mid_rst_no_done", 32'(seen_done), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tetris_grid_renderer.md
Name: tetris_grid_renderer

Overview:
- Parametrised, pipelined playfield renderer. Maps VGA pixel coordinates onto a ROWS x COLS Tetris grid and outputs a 3-bit RGB colour.
- Supports a configurable origin and cell size, separate colours for the falling piece and stored blocks, grid lines, a border, and a gameover tint.
- Runs a line-clear flash animation with a start/busy/done handshake.
- Sits between the game FSM's display arrays and the colour-priority mux feeding the VGA driver.

Parameters:
- ROWS, 20, grid rows; row 0 is the top row.
- COLS, 10, grid columns; column 0 is the leftmost column.
- CELL_LOG2, 4, log2 of the cell edge in pixels (default 16 px).
- X0, 240, pixel x of the grid's left edge.
- Y0, 80, pixel y of the grid's top edge.
- FLASH_PERIOD, 4, frames per flash phase.
- FLASH_PHASES, 6, number of phases per flash sequence.
- LINE_COLOR, 3'b001, grid-line colour.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- x  in  10  current pixel x.
- y  in  10  current pixel y.
- frame_start  in  1  one-cycle pulse once per frame.
- display_array  in  ROWS*COLS  stored-block occupancy; bit index r*COLS+c.
- active_mask  in  ROWS*COLS  falling-piece occupancy; same indexing as display_array.
- active_color  in  3  colour of the falling piece.
- stored_color  in  3  colour of stored blocks.
- gameover  in  1  tints stored blocks red.
- clear_start  in  1  pulse that requests a flash sequence.
- clear_rows  in  ROWS  rows to flash; sampled when clear_start is accepted.
- busy  out  1  high while a flash sequence is in progress.
- clear_done  out  1  one-cycle pulse when a flash sequence ends.
- color_out  out  3  registered pixel colour.

Behaviour:
- Reset:
  - Asynchronous on rst_n low.
  - color_out=0, busy=0, clear_done=0.
  - All pipeline registers, the latched mask and all counters are cleared; FSM goes to IDLE.
- Pipeline latency is 2 clocks from x/y to color_out. The upstream coordinate generator compensates for this.
- Stage 1 registers the following:
  - dx = x-X0 and dy = y-Y0, both 10-bit, unsigned wrap.
  - in_grid = (x>=X0) && (x<X0+COLS<<CELL_LOG2) && (y>=Y0) && (y<Y0+ROWS<<CELL_LOG2).
  - col = dx>>CELL_LOG2 and row = dy>>CELL_LOG2. These are don't-care when !in_grid; no lookup is performed outside the grid.
  - on_line = in_grid && (dx[CELL_LOG2-1:0]==0 || dy[CELL_LOG2-1:0]==0).
  - on_border: pixel lies on the 1-px ring directly outside the grid rectangle.
- Stage 2 selects the colour in strict priority order:
  - border -> 3'b111;
  - !in_grid -> 3'b000;
  - row in flash mask && busy && phase==1 -> 3'b111;
  - active_mask bit -> active_color;
  - display_array bit -> (gameover ? 3'b100 : stored_color);
  - on_line -> LINE_COLOR;
  - otherwise -> 3'b000.
- Flash FSM states: IDLE, FLASH, DONE.
- IDLE:
  - clear_start with |clear_rows: latch mask, frame_cnt=0, phase_cnt=0, phase=1, go to FLASH.
  - clear_start with clear_rows==0: go directly to DONE.
- FLASH:
  - On each frame_start, frame_cnt increments.
  - When frame_cnt reaches FLASH_PERIOD-1: frame_cnt=0, phase toggles, phase_cnt increments.
  - When phase_cnt reaches FLASH_PHASES: go to DONE. Total length is FLASH_PERIOD*FLASH_PHASES frame_starts.
- DONE: clear_done=1 for exactly one cycle, mask cleared, return to IDLE.
- busy = (state != IDLE); it asserts the cycle after acceptance.
- clear_start while busy is ignored and not queued.
- clear_rows changes during FLASH have no effect.
- frame_start and clear_start in the same IDLE cycle: that frame_start is not counted.
- Reset mid-FLASH: immediate return to IDLE; no clear_done.
- Elaboration errors: X0+(COLS<<CELL_LOG2) > 1023; Y0+(ROWS<<CELL_LOG2) > 1023; FLASH_PERIOD or FLASH_PHASES equal to 0.

Decomposition:
- Shared package tetris_pkg holds:
  - color_t (logic [2:0]);
  - colour localparams BLACK, RED, GREEN, BLUE, YELLOW, MAGENTA, CYAN, WHITE;
  - flash_state_t enum {IDLE, FLASH, DONE}.
- One sub-module, line_flash_ctrl, contains the FSM, counters and latched mask. It outputs busy, clear_done, phase and mask.
- The parent holds both pipeline stages and the colour mux.

Test Plan:
- Reset: hold rst_n=0 -> color_out=0, busy=0, clear_done=0. Release with x=0, y=0 -> color_out=000 on every cycle.
- Stored block: display_array[0]=1, stored_color=011, pixel (245,85) -> color_out=011 two clocks later. Set gameover=1 -> color_out=100.
- Piece priority: bit 199 set in both active_mask and display_array, active_color=110, pixel (390,390) (row 19, col 9) -> color_out=110.
- Lines and border:
  - (239,100) -> 111;
  - (256,100) on an empty cell -> 001;
  - (257,101) -> 000;
  - (400,100) -> 111.
- Flash: clear_rows=1<<19, clear_start pulse at defaults, then:
  - busy=1 next cycle;
  - (390,390) shows 111 during frames 0-3 and its normal colour during frames 4-7, alternating;
  - a second clear_start during busy is ignored;
  - single clear_done pulse after the 24th frame_start, then busy=0.
- Edge cases:
  - clear_start with clear_rows=0 -> clear_done pulses 2 cycles later; no visible flash.
  - rst_n=0 at frame 10 of a flash -> busy=0 immediately; clear_done never pulses.
